// File: rtl/rf_wport_arbiter_pkg.sv
// rtl/rf_wport_arbiter_pkg.sv - shared types for the regfile write-port arbiter
// Contents: rf_state_e, the two-state arbiter FSM encoding (CLEAR / RUN).
package rf_wport_arbiter_pkg;

  typedef enum logic {
    RF_ST_CLEAR = 1'b0,
    RF_ST_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - regfile write-port owner: post-reset zero-fill, then WB/mul-div arbitration
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   wb_we, wb_waddr, wb_wdata        WB-stage write (fixed priority, no backpressure)
//   md_valid, md_ready               mul/div result handshake (md_ready is combinational)
//   md_waddr, md_wdata               mul/div destination and result
//   busy                             zero-fill in progress; WB must not write
//   stall_req                        mul/div starved; request a pipeline bubble
//   drop_err                         sticky: a WB write was lost during zero-fill
//   rf_we, rf_waddr, rf_wdata        registered regfile write port
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4,
  parameter int CLEAR_EN = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_waddr,
  input  logic [DW-1:0] wb_wdata,
  input  logic          md_valid,
  output logic          md_ready,
  input  logic [AW-1:0] md_waddr,
  input  logic [DW-1:0] md_wdata,
  output logic          busy,
  output logic          stall_req,
  output logic          drop_err,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);
  localparam logic [AW-1:0]  LAST_REG = AW'(NREG - 1);

  rf_state_e      state_q, state_d;
  logic [AW-1:0]  clr_ptr_q, clr_ptr_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           drop_err_q, drop_err_d;
  logic           rf_we_q, rf_we_d;
  logic [AW-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]  rf_wdata_q, rf_wdata_d;

  // A WB write to x0 is a no-op, so it does not claim the port.
  logic wb_hit;
  assign wb_hit = wb_we && (wb_waddr != '0);

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    drop_err_d = drop_err_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    md_ready   = 1'b0;
    stall_req  = 1'b0;

    case (state_q)
      RF_ST_CLEAR: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = clr_ptr_q;
        rf_wdata_d = '0;
        clr_ptr_d  = clr_ptr_q + 1'b1;
        if (wb_hit) drop_err_d = 1'b1;
        if (clr_ptr_q == LAST_REG) state_d = RF_ST_RUN;
      end
      default: begin
        if (wb_hit) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = wb_waddr;
          rf_wdata_d = wb_wdata;
        end else if (md_valid) begin
          md_ready = 1'b1;
          // md result to x0 is consumed but never reaches the regfile.
          if (md_waddr != '0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = md_waddr;
            rf_wdata_d = md_wdata;
          end
        end
      end
    endcase

    if (md_valid && !md_ready) begin
      if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
    end else if (md_valid) begin
      wait_cnt_d = '0;
    end

    stall_req = md_valid && (wait_cnt_q == WAIT_MAX);

    // Handshake outputs are held low while reset is asserted.
    if (reset) begin
      md_ready  = 1'b0;
      stall_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= (CLEAR_EN != 0) ? RF_ST_CLEAR : RF_ST_RUN;
      clr_ptr_q  <= AW'(1);
      wait_cnt_q <= '0;
      drop_err_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      drop_err_q <= drop_err_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign busy     = (state_q == RF_ST_CLEAR);
  assign drop_err = drop_err_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule
